fifo_wr_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the team's synchronous FIFO among NUM_REQ requesters.
- Sequences each write as select → write → check response, using the FIFO's full, wr_ack and overflow outputs.
- Retries a write that overflows and counts overflow events.
- Sits between producer blocks and the FIFO's wr_en/data_in inputs.

---
 rtl/fifo_wr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one synchronous FIFO write port among NUM_REQ requesters.
// Each word goes through select, write and response; overflowed or unanswered words are retried.
module fifo_wr_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [NUM_REQ-1:0]            req_i,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
    output logic [NUM_REQ-1:0]            done_o,
    output logic                          fifo_wr_en_o,
    output logic [DATA_WIDTH-1:0]         fifo_data_in_o,
    input  logic                          fifo_full_i,
    input  logic                          fifo_wr_ack_i,
    input  logic                          fifo_overflow_i,
    output logic [CNT_WIDTH-1:0]          ovf_count_o,
    output logic                          proto_err_o,
    output logic                          busy_o
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef logic [IDX_W-1:0] idx_t;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    idx_t                  winner_q, winner_d;
    idx_t                  rr_ptr_q, rr_ptr_d;
    logic                  lock_q, lock_d;
    logic                  wr_en_q, wr_en_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [CNT_WIDTH-1:0]  ovf_cnt_q, ovf_cnt_d;
    logic                  perr_q, perr_d;
    logic                  busy_q;

    logic [DATA_WIDTH-1:0] req_word [NUM_REQ];
    logic                  pick_valid;
    idx_t                  pick_idx;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign req_word[g] = req_data_i[g*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic idx_t rr_index(input idx_t base, input int offset);
        int sum;
        sum = int'(base) + offset;
        if (sum >= NUM_REQ) begin
            sum = sum - NUM_REQ;
        end
        return idx_t'(sum);
    endfunction

    // First active request at or after rr_ptr, wrapping around.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!pick_valid && req_i[rr_index(rr_ptr_q, k)]) begin
                pick_valid = 1'b1;
                pick_idx   = rr_index(rr_ptr_q, k);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        winner_d  = winner_q;
        rr_ptr_d  = rr_ptr_q;
        lock_d    = lock_q;
        wr_en_d   = 1'b0;
        data_d    = data_q;
        done_d    = '0;
        ovf_cnt_d = ovf_cnt_q;
        perr_d    = perr_q;

        unique case (state_q)
            IDLE: begin
                if (!fifo_full_i) begin
                    if (lock_q) begin
                        state_d = WRITE;
                        wr_en_d = 1'b1;
                    end else if (pick_valid) begin
                        winner_d = pick_idx;
                        data_d   = req_word[pick_idx];
                        state_d  = WRITE;
                        wr_en_d  = 1'b1;
                    end
                end
            end

            WRITE: begin
                state_d = RESP;
            end

            RESP: begin
                state_d = IDLE;
                if (fifo_wr_ack_i) begin
                    done_d[winner_q] = 1'b1;
                    lock_d           = 1'b0;
                    if (winner_q == idx_t'(NUM_REQ - 1)) begin
                        rr_ptr_d = '0;
                    end else begin
                        rr_ptr_d = winner_q + idx_t'(1);
                    end
                end else begin
                    // Missing response is retried like an overflow but flagged instead of counted.
                    lock_d = 1'b1;
                    if (fifo_overflow_i) begin
                        if (ovf_cnt_q != {CNT_WIDTH{1'b1}}) begin
                            ovf_cnt_d = ovf_cnt_q + CNT_WIDTH'(1);
                        end
                    end else begin
                        perr_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            winner_q  <= '0;
            rr_ptr_q  <= '0;
            lock_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            data_q    <= '0;
            done_q    <= '0;
            ovf_cnt_q <= '0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            rr_ptr_q  <= rr_ptr_d;
            lock_q    <= lock_d;
            wr_en_q   <= wr_en_d;
            data_q    <= data_d;
            done_q    <= done_d;
            ovf_cnt_q <= ovf_cnt_d;
            perr_q    <= perr_d;
            busy_q    <= (state_d != IDLE);
        end
    end

    assign done_o         = done_q;
    assign fifo_wr_en_o   = wr_en_q;
    assign fifo_data_in_o = data_q;
    assign ovf_count_o    = ovf_cnt_q;
    assign proto_err_o    = perr_q;
    assign busy_o         = busy_q;

    a_wr_en_single: assert property (@(posedge clk_i) disable iff (rst_i)
        fifo_wr_en_o |=> !fifo_wr_en_o);
    a_done_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        $onehot0(done_o));

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Scoreboard bench for fifo_wr_arbiter: a transaction-level model predicts writes, done pulses
// and status; a negedge monitor compares the DUT against the predicted event queues.
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 16;
    localparam int CNT_WIDTH  = 8;
    localparam int CNT_MAX    = (1 << CNT_WIDTH) - 1;

    localparam int RESP_ACK  = 0;
    localparam int RESP_OVF  = 1;
    localparam int RESP_NONE = 2;
    localparam int RESP_BOTH = 3;

    typedef struct {
        int                    cyc;
        logic [DATA_WIDTH-1:0] data;
    } wrEvt_t;

    typedef struct {
        int cyc;
        int idx;
    } doneEvt_t;

    logic                          clk = 1'b0;
    logic                          rst = 1'b1;
    logic [NUM_REQ-1:0]            req = '0;
    logic [NUM_REQ*DATA_WIDTH-1:0] reqData = '0;
    logic                          fifoFull = 1'b0;
    logic                          fifoWrAck = 1'b0;
    logic                          fifoOverflow = 1'b0;
    logic [NUM_REQ-1:0]            done;
    logic                          fifoWrEn;
    logic [DATA_WIDTH-1:0]         fifoDataIn;
    logic [CNT_WIDTH-1:0]          ovfCount;
    logic                          protoErr;
    logic                          busy;

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .DATA_WIDTH(DATA_WIDTH),
        .CNT_WIDTH (CNT_WIDTH)
    ) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .req_i          (req),
        .req_data_i     (reqData),
        .done_o         (done),
        .fifo_wr_en_o   (fifoWrEn),
        .fifo_data_in_o (fifoDataIn),
        .fifo_full_i    (fifoFull),
        .fifo_wr_ack_i  (fifoWrAck),
        .fifo_overflow_i(fifoOverflow),
        .ovf_count_o    (ovfCount),
        .proto_err_o    (protoErr),
        .busy_o         (busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cycleNow = 0;
    bit monOn = 1'b0;

    // Model: transaction age is -1 when free, 1 in the issue cycle, 2 in the response cycle.
    int                    mRr = 0;
    int                    mWinner = 0;
    int                    mAge = -1;
    int                    mResp = RESP_ACK;
    int                    mOvf = 0;
    bit                    mLocked = 1'b0;
    bit                    mPerr = 1'b0;
    logic [DATA_WIDTH-1:0] mLockData = '0;
    int                    justDone = -1;

    int       respPlan[$];
    wrEvt_t   wrQ[$];
    doneEvt_t doneQ[$];

    bit randResp = 1'b0;
    bit randReq  = 1'b0;
    bit randFull = 1'b0;
    bit reraise  = 1'b0;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycleNow);
        end
    endtask

    function automatic int nextResp();
        int r;
        if (respPlan.size() > 0) begin
            return respPlan.pop_front();
        end
        if (!randResp) begin
            return RESP_ACK;
        end
        r = $urandom_range(0, 99);
        if (r < 70) return RESP_ACK;
        if (r < 88) return RESP_OVF;
        if (r < 94) return RESP_BOTH;
        return RESP_NONE;
    endfunction

    task automatic modelEdge();
        bit issue;
        issue = 1'b0;
        if (rst) begin
            mAge = -1; mRr = 0; mWinner = 0; mLocked = 1'b0;
            mOvf = 0; mPerr = 1'b0; justDone = -1;
            wrQ.delete();
            doneQ.delete();
            return;
        end
        if (mAge == 2) begin
            if (mResp == RESP_ACK || mResp == RESP_BOTH) begin
                doneQ.push_back('{cyc: cycleNow, idx: mWinner});
                mRr      = (mWinner + 1) % NUM_REQ;
                mLocked  = 1'b0;
                justDone = mWinner;
            end else begin
                mLocked = 1'b1;
                if (mResp == RESP_OVF) begin
                    if (mOvf < CNT_MAX) mOvf++;
                end else begin
                    mPerr = 1'b1;
                end
            end
            mAge = -1;
        end else if (mAge == 1) begin
            mAge = 2;
        end else if (!fifoFull) begin
            if (mLocked) begin
                issue = 1'b1;
            end else begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    int c;
                    c = (mRr + k) % NUM_REQ;
                    if (req[c]) begin
                        mWinner   = c;
                        mLockData = reqData[c*DATA_WIDTH +: DATA_WIDTH];
                        issue     = 1'b1;
                        break;
                    end
                end
            end
            if (issue) begin
                wrQ.push_back('{cyc: cycleNow, data: mLockData});
                mAge  = 1;
                mResp = nextResp();
            end
        end
    endtask

    task automatic setReq(input int i, input logic [DATA_WIDTH-1:0] d);
        reqData[i*DATA_WIDTH +: DATA_WIDTH] = d;
        req[i] = 1'b1;
    endtask

    // Drives FIFO responses and requester behaviour for the cycle that just started.
    task automatic applyStimulus();
        fifoWrAck    = (mAge == 2) && (mResp == RESP_ACK || mResp == RESP_BOTH);
        fifoOverflow = (mAge == 2) && (mResp == RESP_OVF || mResp == RESP_BOTH);
        if (justDone >= 0) begin
            if (reraise) setReq(justDone, DATA_WIDTH'($urandom));
            else req[justDone] = 1'b0;
            justDone = -1;
        end
        if (randReq) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req[i] && $urandom_range(0, 99) < 30) setReq(i, DATA_WIDTH'($urandom));
            end
        end
        if (randFull) fifoFull = ($urandom_range(0, 99) < 15);
    endtask

    task automatic stepCycle();
        @(posedge clk);
        cycleNow++;
        modelEdge();
        #1;
        applyStimulus();
    endtask

    task automatic stepN(input int n);
        for (int i = 0; i < n; i++) stepCycle();
    endtask

    task automatic doReset();
        req = '0;
        fifoFull = 1'b0;
        respPlan.delete();
        rst = 1'b1;
        stepN(2);
        rst = 1'b0;
        monOn = 1'b1;
    endtask

    task automatic runUntilIdle(input string name, input int limit);
        int n;
        n = 0;
        while (!(req == '0 && mAge == -1 && !mLocked) && n < limit) begin
            stepCycle();
            n++;
        end
        if (n >= limit) checkOutput({name, "Timeout"}, 64'(0), 64'(1));
    endtask

    task automatic checkAllZero(input string name);
        checkOutput({name, "Done"},  64'(done),       64'(0));
        checkOutput({name, "WrEn"},  64'(fifoWrEn),   64'(0));
        checkOutput({name, "Data"},  64'(fifoDataIn), 64'(0));
        checkOutput({name, "Ovf"},   64'(ovfCount),   64'(0));
        checkOutput({name, "Perr"},  64'(protoErr),   64'(0));
        checkOutput({name, "Busy"},  64'(busy),       64'(0));
    endtask

    always @(negedge clk) begin
        if (monOn) begin
            while (wrQ.size() > 0 && wrQ[0].cyc < cycleNow) begin
                checkOutput("wrMissed", 64'(0), 64'(1));
                void'(wrQ.pop_front());
            end
            if (wrQ.size() > 0 && wrQ[0].cyc == cycleNow) begin
                checkOutput("wrEnAtIssue", 64'(fifoWrEn), 64'(1));
                checkOutput("wrData", 64'(fifoDataIn), 64'(wrQ[0].data));
                void'(wrQ.pop_front());
            end else if (fifoWrEn !== 1'b0) begin
                checkOutput("wrEnSpurious", 64'(fifoWrEn), 64'(0));
            end
            while (doneQ.size() > 0 && doneQ[0].cyc < cycleNow) begin
                checkOutput("doneMissed", 64'(0), 64'(1));
                void'(doneQ.pop_front());
            end
            if (doneQ.size() > 0 && doneQ[0].cyc == cycleNow) begin
                checkOutput("donePulse", 64'(done), 64'(1) << doneQ[0].idx);
                void'(doneQ.pop_front());
            end else if (done !== '0) begin
                checkOutput("doneSpurious", 64'(done), 64'(0));
            end
            checkOutput("ovfCount", 64'(ovfCount), 64'(mOvf));
            checkOutput("protoErr", 64'(protoErr), 64'(mPerr));
            checkOutput("busy", 64'(busy), 64'(mAge != -1));
        end
    end

    initial begin
        doReset();
        checkAllZero("reset");

        // Single requester: write one cycle after sampling, done two cycles after the write.
        setReq(2, 16'h00A5);
        stepCycle();
        checkOutput("singleWrEn", 64'(fifoWrEn), 64'(1));
        checkOutput("singleData", 64'(fifoDataIn), 64'(16'h00A5));
        stepN(2);
        checkOutput("singleDone", 64'(done), 64'(4'b0100));
        runUntilIdle("single", 20);

        // All requesters held: served 0,1,2,3,0 three cycles apart.
        doReset();
        reraise = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) setReq(i, DATA_WIDTH'(16'h1000 + i));
        stepN(3);
        checkOutput("fairDone0", 64'(done), 64'(4'b0001));
        stepN(3);
        checkOutput("fairDone1", 64'(done), 64'(4'b0010));
        stepN(3);
        checkOutput("fairDone2", 64'(done), 64'(4'b0100));
        stepN(3);
        checkOutput("fairDone3", 64'(done), 64'(4'b1000));
        stepN(3);
        checkOutput("fairDone0b", 64'(done), 64'(4'b0001));
        reraise = 1'b0;
        req = '0;
        runUntilIdle("fair", 20);

        // Full backpressure holds off selection entirely.
        fifoFull = 1'b1;
        setReq(1, 16'h5A5A);
        for (int i = 0; i < 10; i++) begin
            stepCycle();
            checkOutput("fullWrEn", 64'(fifoWrEn), 64'(0));
            checkOutput("fullBusy", 64'(busy), 64'(0));
        end
        fifoFull = 1'b0;
        stepCycle();
        checkOutput("fullReleaseWrEn", 64'(fifoWrEn), 64'(1));
        checkOutput("fullReleaseData", 64'(fifoDataIn), 64'(16'h5A5A));
        runUntilIdle("full", 20);

        // Overflow retry: requester 3 retried before requester 0 is considered.
        doReset();
        setReq(2, 16'h0002);
        runUntilIdle("ovfPrep", 20);
        respPlan = '{RESP_OVF, RESP_ACK, RESP_ACK};
        setReq(0, 16'hBEEF);
        setReq(3, 16'h1234);
        stepCycle();
        checkOutput("ovfFirstData", 64'(fifoDataIn), 64'(16'h1234));
        stepN(3);
        checkOutput("ovfRetryWrEn", 64'(fifoWrEn), 64'(1));
        checkOutput("ovfRetryData", 64'(fifoDataIn), 64'(16'h1234));
        checkOutput("ovfCountOne", 64'(ovfCount), 64'(1));
        runUntilIdle("ovf", 40);

        // Counter saturation followed by a withheld response.
        doReset();
        for (int i = 0; i < 300; i++) respPlan.push_back(RESP_OVF);
        respPlan.push_back(RESP_NONE);
        respPlan.push_back(RESP_ACK);
        setReq(1, 16'hC0DE);
        runUntilIdle("sat", 1200);
        checkOutput("satCount", 64'(ovfCount), 64'(CNT_MAX));
        checkOutput("protoErrSet", 64'(protoErr), 64'(1));
        setReq(2, 16'h7777);
        runUntilIdle("sticky", 40);
        checkOutput("protoErrSticky", 64'(protoErr), 64'(1));
        doReset();
        checkOutput("protoErrCleared", 64'(protoErr), 64'(0));

        // Randomised traffic, backpressure and responses.
        randReq = 1'b1;
        randFull = 1'b1;
        randResp = 1'b1;
        stepN(1500);
        randReq = 1'b0;
        randFull = 1'b0;
        randResp = 1'b0;
        fifoFull = 1'b0;
        reraise = 1'b0;
        runUntilIdle("random", 300);

        // Reset during WRITE abandons the word and restarts round-robin at 0.
        doReset();
        setReq(1, 16'h0101);
        runUntilIdle("midPrep", 20);
        setReq(0, 16'h0C0C);
        setReq(2, 16'h2222);
        begin
            int n;
            n = 0;
            while (mAge != 1 && n < 10) begin
                stepCycle();
                n++;
            end
            if (n >= 10) checkOutput("midIssueTimeout", 64'(0), 64'(1));
        end
        checkOutput("midWriteData", 64'(fifoDataIn), 64'(16'h2222));
        rst = 1'b1;
        stepCycle();
        checkAllZero("midReset");
        rst = 1'b0;
        stepCycle();
        checkOutput("midRestartWrEn", 64'(fifoWrEn), 64'(1));
        checkOutput("midRestartData", 64'(fifoDataIn), 64'(16'h0C0C));
        runUntilIdle("mid", 40);
        stepN(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
